// File: rtl/uart_tx_scheduler_if.sv
`default_nettype none
// ------------------------------------------------------------------
// uart_tx_scheduler_if : requester bus for the shared UART TX framer
// rev 1.0
// ------------------------------------------------------------------
interface uart_tx_scheduler_if #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 7
);
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*DATA_W-1:0] data_in;
  logic [NUM_REQ-1:0]        grant;
  logic [2:0]                grant_id;
  logic                      busy;
  logic                      done;
  logic                      tx;

  modport master (output req, data_in, input grant, grant_id, busy, done, tx);
  modport slave  (input req, data_in, output grant, grant_id, busy, done, tx);
endinterface
`default_nettype wire

// File: rtl/uart_tx_scheduler.sv
`default_nettype none
// ------------------------------------------------------------------
// uart_tx_scheduler : round-robin arbiter + 7E1-style frame serializer
// rev 1.0
// ------------------------------------------------------------------
module uart_tx_scheduler #(
  parameter int NUM_REQ      = 4,
  parameter int DATA_W       = 7,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic                 sys_clk,
  input  logic                 rst_n,
  uart_tx_scheduler_if.slave   bus
);
  localparam int ID_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W  = $clog2(DATA_W + 1);

  localparam logic [ID_W-1:0]   ID_LAST   = ID_W'(NUM_REQ - 1);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BAUD_W-1:0] BAUD_PRE  = BAUD_W'(CLKS_PER_BIT - 2);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_W - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t              state;
  logic [BAUD_W-1:0]   baud_cnt;
  logic [BIT_W-1:0]    bit_cnt;
  logic [DATA_W-1:0]   shift_reg;
  logic                parity;
  logic [ID_W-1:0]     ptr;

  logic                found;
  logic [ID_W-1:0]     win;
  logic [ID_W-1:0]     cand;
  logic [DATA_W-1:0]   win_word;

  // Scan starts one past the last winner so every pending requester gets a turn.
  always_comb begin
    found = 1'b0;
    win   = '0;
    cand  = ptr;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = (cand == ID_LAST) ? '0 : cand + ID_W'(1);
      if (!found && bus.req[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  always_comb begin
    win_word = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win == ID_W'(i)) win_word = bus.data_in[i*DATA_W +: DATA_W];
    end
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      baud_cnt     <= '0;
      bit_cnt      <= '0;
      shift_reg    <= '0;
      parity       <= 1'b0;
      ptr          <= ID_LAST;
      bus.grant    <= '0;
      bus.grant_id <= '0;
      bus.busy     <= 1'b0;
      bus.done     <= 1'b0;
      bus.tx       <= 1'b1;
    end else begin
      bus.done <= 1'b0;
      case (state)
        S_IDLE: begin
          bus.tx   <= 1'b1;
          baud_cnt <= '0;
          bit_cnt  <= '0;
          if (found) begin
            shift_reg    <= win_word;
            parity       <= ^win_word;
            bus.grant    <= NUM_REQ'(1) << win;
            bus.grant_id <= 3'(win);
            bus.busy     <= 1'b1;
            ptr          <= win;
            bus.tx       <= 1'b0;
            state        <= S_START;
          end
        end
        default: begin
          if (baud_cnt == BAUD_LAST) begin
            baud_cnt <= '0;
            case (state)
              S_START: begin
                bus.tx  <= shift_reg[DATA_W-1];
                bit_cnt <= '0;
                state   <= S_DATA;
              end
              S_DATA: begin
                if (bit_cnt == BIT_LAST) begin
                  bus.tx <= parity;
                  state  <= S_PARITY;
                end else begin
                  shift_reg <= {shift_reg[DATA_W-2:0], 1'b0};
                  bus.tx    <= shift_reg[DATA_W-2];
                  bit_cnt   <= bit_cnt + BIT_W'(1);
                end
              end
              S_PARITY: begin
                bus.tx <= 1'b1;
                state  <= S_STOP;
              end
              default: begin
                bus.grant    <= '0;
                bus.grant_id <= '0;
                bus.busy     <= 1'b0;
                state        <= S_IDLE;
              end
            endcase
          end else begin
            baud_cnt <= baud_cnt + BAUD_W'(1);
            // Registered, so raise it one cycle early to land on the last stop cycle.
            if (state == S_STOP && baud_cnt == BAUD_PRE) bus.done <= 1'b1;
          end
        end
      endcase
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_uart_tx_scheduler.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_uart_tx_scheduler : directed checks of arbitration and framing
// rev 1.0
// ------------------------------------------------------------------
module tb_uart_tx_scheduler;
  localparam int NUM_REQ = 4;
  localparam int DATA_W  = 7;
  localparam int CPB     = 16;
  localparam int FRAME   = (DATA_W + 3) * CPB;

  logic sys_clk = 1'b0;
  logic rst_n   = 1'b0;
  always #5 sys_clk = ~sys_clk;

  uart_tx_scheduler_if #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W)) bus ();

  uart_tx_scheduler #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .CLKS_PER_BIT(CPB)) dut (
    .sys_clk (sys_clk),
    .rst_n   (rst_n),
    .bus     (bus)
  );

  typedef struct {
    logic [3:0] req;
    int         slot;
    logic [6:0] word;
    logic [3:0] exp_grant;
    logic [2:0] exp_id;
    logic [9:0] exp_frame;   // start, data MSB first, parity, stop
  } vec_t;

  vec_t vecs[5];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic wait_busy(input int limit, output int cycles);
    cycles = 0;
    while (!bus.busy && cycles < limit) begin
      @(negedge sys_clk);
      cycles++;
    end
  endtask

  // Entered at the negedge of the first frame cycle; leaves at the done cycle.
  task automatic capture_frame(output logic [9:0] frame, output int done_cnt,
                               output int done_at, output logic grant_ok);
    logic [3:0] g0;
    frame = '0; done_cnt = 0; done_at = -1; grant_ok = 1'b1;
    g0 = bus.grant;
    for (int t = 0; t < FRAME; t++) begin
      if (t > 0) @(negedge sys_clk);
      if (t % CPB == CPB / 2) frame = {frame[8:0], bus.tx};
      if (bus.done) begin done_cnt++; done_at = t; end
      if (bus.grant !== g0 || !bus.busy) grant_ok = 1'b0;
    end
  endtask

  task automatic check_idle(input string name);
    chk({name, "_busy"},  32'(bus.busy), 0);
    chk({name, "_tx"},    32'(bus.tx), 1);
    chk({name, "_grant"}, 32'(bus.grant), 0);
  endtask

  initial begin
    logic [9:0] frame;
    int cyc, dcnt, dat, errs, nstarts, prev_cyc;
    logic gok, prev_busy;
    int   start_cyc[5];
    int   start_id[5];
    int   exp_order[5];

    vecs[0] = '{4'b0100, 2, 7'b1011001, 4'b0100, 3'd2, 10'b0101100101};
    vecs[1] = '{4'b0010, 1, 7'b0000001, 4'b0010, 3'd1, 10'b0000000111};
    vecs[2] = '{4'b1000, 3, 7'b1010101, 4'b1000, 3'd3, 10'b0101010101};
    vecs[3] = '{4'b1010, 1, 7'b1100110, 4'b0010, 3'd1, 10'b0110011001};
    vecs[4] = '{4'b1000, 3, 7'b0111000, 4'b1000, 3'd3, 10'b0011100011};
    exp_order = '{0, 1, 2, 3, 0};

    bus.req = '0;
    bus.data_in = '0;

    // Reset hold, then mid-cycle release
    errs = 0;
    repeat (100) begin
      @(negedge sys_clk);
      if (bus.tx !== 1'b1 || bus.grant !== 4'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0) errs++;
    end
    chk("reset_hold", 32'(errs), 0);
    chk("reset_id", 32'(bus.grant_id), 0);
    #2 rst_n = 1'b1;
    #1 chk("release_tx", 32'(bus.tx), 1);
    errs = 0;
    repeat (5) begin
      @(negedge sys_clk);
      if (bus.tx !== 1'b1 || bus.busy !== 1'b0 || bus.done !== 1'b0) errs++;
    end
    chk("post_release_idle", 32'(errs), 0);

    for (int v = 0; v < 5; v++) begin
      bus.req = vecs[v].req;
      bus.data_in = {NUM_REQ{7'b0101010}};
      bus.data_in[vecs[v].slot*DATA_W +: DATA_W] = vecs[v].word;
      wait_busy(400, cyc);
      chk($sformatf("v%0d_latency", v), 32'(cyc), 1);
      chk($sformatf("v%0d_grant", v), 32'(bus.grant), 32'(vecs[v].exp_grant));
      chk($sformatf("v%0d_id", v), 32'(bus.grant_id), 32'(vecs[v].exp_id));
      chk($sformatf("v%0d_tx_start", v), 32'(bus.tx), 0);
      capture_frame(frame, dcnt, dat, gok);
      chk($sformatf("v%0d_frame", v), 32'(frame), 32'(vecs[v].exp_frame));
      chk($sformatf("v%0d_done_cnt", v), 32'(dcnt), 1);
      chk($sformatf("v%0d_done_at", v), 32'(dat), FRAME - 1);
      chk($sformatf("v%0d_grant_stable", v), 32'(gok), 1);
      bus.req = '0;
      @(negedge sys_clk);
      check_idle($sformatf("v%0d_after", v));
    end

    // All requesters held: round-robin order and 161-cycle spacing
    bus.req = 4'b1111;
    bus.data_in = {7'h44, 7'h33, 7'h22, 7'h11};
    nstarts = 0; prev_busy = 1'b0; cyc = 0;
    while (nstarts < 5 && cyc < 5 * (FRAME + 1) + 50) begin
      @(negedge sys_clk);
      cyc++;
      if (bus.busy && !prev_busy) begin
        start_cyc[nstarts] = cyc;
        start_id[nstarts]  = int'(bus.grant_id);
        chk($sformatf("rr%0d_onehot", nstarts), 32'(bus.grant), 32'(4'b0001 << bus.grant_id));
        nstarts++;
      end
      prev_busy = bus.busy;
    end
    chk("rr_starts", 32'(nstarts), 5);
    prev_cyc = -1;
    for (int i = 0; i < nstarts; i++) begin
      chk($sformatf("rr%0d_id", i), 32'(start_id[i]), 32'(exp_order[i]));
      if (i > 0) chk($sformatf("rr%0d_period", i), 32'(start_cyc[i] - prev_cyc), FRAME + 1);
      prev_cyc = start_cyc[i];
    end
    bus.req = '0;
    cyc = 0;
    while (bus.busy && cyc < FRAME + 20) begin
      @(negedge sys_clk);
      cyc++;
    end
    chk("rr_drain", 32'(bus.busy), 0);
    @(negedge sys_clk);

    // Mid-frame data change and req drop are ignored
    bus.req = 4'b0001;
    bus.data_in = '0;
    bus.data_in[6:0] = 7'b1111111;
    wait_busy(400, cyc);
    chk("mid_latency", 32'(cyc), 1);
    chk("mid_grant", 32'(bus.grant), 32'(4'b0001));
    bus.data_in[6:0] = 7'b0000000;
    bus.req = '0;
    capture_frame(frame, dcnt, dat, gok);
    chk("mid_frame", 32'(frame), 32'(10'b0111111111));
    chk("mid_done_at", 32'(dat), FRAME - 1);
    chk("mid_grant_stable", 32'(gok), 1);
    @(negedge sys_clk);
    check_idle("mid_after");

    // Asynchronous reset during DATA, then a clean frame after release
    bus.req = 4'b0010;
    bus.data_in = '0;
    bus.data_in[1*DATA_W +: DATA_W] = 7'b1010101;
    wait_busy(400, cyc);
    chk("rst_pre_id", 32'(bus.grant_id), 1);
    repeat (40) @(negedge sys_clk);
    chk("rst_pre_tx", 32'(bus.tx), 0);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_tx", 32'(bus.tx), 1);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_grant", 32'(bus.grant), 0);
    chk("rst_done", 32'(bus.done), 0);
    repeat (3) @(negedge sys_clk);
    chk("rst_hold_tx", 32'(bus.tx), 1);
    rst_n = 1'b1;
    wait_busy(400, cyc);
    chk("rst_new_latency", 32'(cyc), 1);
    chk("rst_new_id", 32'(bus.grant_id), 1);
    capture_frame(frame, dcnt, dat, gok);
    chk("rst_new_frame", 32'(frame), 32'(10'b0101010101));
    chk("rst_new_done_cnt", 32'(dcnt), 1);
    bus.req = '0;
    @(negedge sys_clk);
    check_idle("rst_new_after");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/uart_tx_scheduler.md
Name: uart_tx_scheduler

Overview:
Shares one serial transmit line between NUM_REQ requesters. A round-robin arbiter grants one requester at a time. The block then serializes that requester's 7-bit word into a frame: start bit, data MSB-first, even parity, stop bit. The frame format matches our 7-bit + parity UART receiver, so the block is the transmit-side sequencer for that link.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
DATA_W, 7, data bits per frame
CLKS_PER_BIT, 16, sys_clk cycles per serial bit (>=2)

Ports:
sys_clk  in  1  system clock, all logic on rising edge
rst_n  in  1  asynchronous, active-low reset
req  in  NUM_REQ  per-requester transmit request, level
data_in  in  NUM_REQ*DATA_W  requester i word at bits [i*DATA_W +: DATA_W]
grant  out  NUM_REQ  one-hot, owner of the current frame
grant_id  out  3  binary index of granted requester (valid while busy)
busy  out  1  frame in progress
done  out  1  one-cycle pulse, last cycle of stop bit
tx  out  1  serial line, idles high, registered

Behaviour:
- Reset (async assert, sync release): tx=1, grant=0, grant_id=0, busy=0, done=0, state=IDLE, bit/baud counters=0, rr pointer=NUM_REQ-1 (req[0] has first priority).
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE: tx=1. On an edge with any req bit high:
  - select the first set req scanning from (ptr+1) mod NUM_REQ upward, with wrap;
  - latch that requester's data_in into shift_reg and parity = ^data;
  - set grant one-hot, grant_id, busy=1, ptr=winner; tx<=0; go to START.
  - Latency: tx falls and grant rises one cycle after req is first sampled.
- Each of START, DATA, PARITY and STOP holds tx for exactly CLKS_PER_BIT cycles, timed by a baud counter that counts 0..CLKS_PER_BIT-1.
- START to DATA: tx<=shift_reg[DATA_W-1] (MSB first).
- DATA: on each bit boundary, shift left and drive the next bit. After DATA_W bits, go to PARITY with tx<=parity (even: XOR of the data bits).
- PARITY to STOP: tx<=1.
- STOP, last cycle: done=1 (with grant still set). Next edge: IDLE, grant=0, busy=0.
- Frame length = (DATA_W+3)*CLKS_PER_BIT cycles; 160 with defaults. There is at least one IDLE cycle (tx high) between consecutive frames.
- Back-to-back frames with all req held: period = frame length + 1 cycle; 161 with defaults.
- Mid-frame, req and data_in are ignored: data is latched at grant and a req drop does not abort the frame.
- Requesters must drop req on the cycle after done to avoid a repeat grant. A req still high is simply re-arbitrated; because ptr has advanced, other pending requesters win first.
- Single requester holding req high is regranted every frame.
- Simultaneous req changes on the arbitration edge: the sampled values on that edge decide.
- Reset asserted mid-frame: immediate return to reset values; tx goes high at once (a truncated frame shows as a framing error at the receiver, which is acceptable). No frame resumes after release.
- grant is never multi-hot. done is never asserted outside STOP.

Test Plan:
- Reset with all req=0 -> tx=1, grant=0, busy=0, done=0 held for 100 cycles. Release mid-cycle with no glitch on tx.
- req[2]=1, data word 2 = 7'b1011001 (defaults) -> tx low for 16 cycles, then 1,0,1,1,0,0,1 at 16 cycles each, then parity 0, then stop 1. done pulses at cycle 160 after the frame starts. grant=4'b0100, grant_id=2.
- req=4'b1111 held, distinct words -> grant order 0,1,2,3,0 with frame starts exactly 161 cycles apart.
- Only req[3] held after one grant to req[1] -> next grant is 3. Then req[1] and req[3] both high -> grant 1 before 3 (wrap fairness).
- During a frame for req[0], change data_in[0] and drop req[0] -> serialized bits match the value latched at grant and the frame completes. Word 7'b1111111 gives parity 1.
- Assert rst_n=0 during the DATA state -> tx=1, busy=0, grant=0 within the same cycle. After release with req[1] set, a full new frame starts for requester 1.
